clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Run-time programmable clock-divider controller. It generates a divided clock `clk_out` and a one-cycle `tick` strobe from `clk_in`. Enable/disable and divisor changes are sequenced so that they only take effect on a period boundary, which keeps `clk_out` free of runt pulses and truncated phases. It sits between a register interface or host FSM and the logic clocked or enabled by the divided output, and replaces fixed-ratio dividers wherever the ratio must change at run time.

## Interface
- `CNT_W`, default 8: width of the divisor and of the internal phase counter.
- `RESET_DIV`, default 4: divisor loaded at reset. Must be legal (see Operation).

- `clk_in`, input, 1: single clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: run request. Level sensitive.
- `cfg_valid`, input, 1: new divisor offered.
- `cfg_div`, input, CNT_W: requested divisor N.
- `cfg_ready`, output, 1: controller can accept `cfg_div`.
- `cfg_err`, output, 1: one-cycle pulse when an accepted divisor is illegal.
- `clk_out`, output, 1: registered divided clock.
- `tick`, output, 1: high in the first cycle of each `clk_out` high phase.
- `busy`, output, 1: high while in RUN.
- `active_div`, output, CNT_W: divisor currently in effect.

## Operation
- **Reset values:** `clk_out`=0, `tick`=0, `cfg_ready`=1, `cfg_err`=0, `busy`=0, `active_div`=RESET_DIV. State is STOP and there is no pending divisor.
- **Phase lengths:** high phase H = ceil(N/2) cycles, low phase L = floor(N/2) cycles. The counter loads H-1 or L-1 and counts down. A phase ends when the counter reaches 0.
- **Legal divisors:** N ≥ 2 and N even. Odd N is legal only with CLKDIV_ODD_EN.
- **STOP:**
  - `clk_out`=0.
  - An accepted legal divisor is written to `active_div` on the accepting edge.
  - If `en`=1 is sampled, then on that edge: `clk_out`←1, `tick`←1, counter←H-1, state←RUN.
- **RUN:**
  - `clk_out` toggles at the end of each phase.
  - The period boundary is the last cycle of the low phase.
- **Boundary rules:**
  - If a divisor is pending, `active_div`←pending, the pending register is cleared and `cfg_ready`←1.
  - If `en`=0 at the boundary, state←STOP and `clk_out` stays 0.
  - Otherwise a new period starts with the new H: `clk_out`←1, `tick`←1.
- **Disable:** deasserting `en` never shortens a phase. The current period always completes.
- **Config handshake:**
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both high.
  - In RUN, a legal divisor goes to the pending register and `cfg_ready`←0 until the boundary that applies it.
  - An illegal divisor (0, 1, or odd without the macro) is accepted and discarded. `cfg_err` pulses on the following cycle; `active_div` and the pending register are unchanged.
- **Simultaneous events:**
  - A transfer in the boundary cycle is not applied at that boundary; it is applied at the next one.
  - If that boundary also enters STOP, the pending divisor is applied in the first STOP cycle.
- **Reset mid-operation:** a synchronous `rst` forces all reset values on the next edge regardless of phase. Any pending divisor is discarded.

## Timing
- `en` to first `clk_out` rise: 1 cycle (the edge that samples `en`=1 in STOP).
- `tick` coincides with the first high cycle of every period. Spacing between ticks is exactly `active_div` cycles.
- Divisor change latency:
  - In STOP: 1 edge.
  - In RUN: takes effect at the first boundary after acceptance, and the following period uses the new N.
- `busy` falls on the edge that leaves RUN, so `clk_out` and `busy` are both 0 from that cycle.
- `cfg_err` is 1 cycle after the accepting edge, and is exactly 1 cycle wide.

## Configuration
- **`CLKDIV_ODD_EN` defined:**
  - Odd N ≥ 3 is legal.
  - High phase is (N+1)/2 cycles and low phase is (N-1)/2 cycles.
  - Example: N=5 gives pattern 11100.
- **`CLKDIV_ODD_EN` undefined:**
  - Odd N is illegal: `cfg_err` pulses and the divisor is discarded.
  - Duty cycle is always exactly 50%.

## Test plan
- **Default run:** reset, `en`=1 from cycle 0 → `clk_out` = 1100 repeating starting 1 cycle later, `tick` every 4 cycles, `busy`=1, `active_div`=4.
- **Reconfigure mid-period:** in RUN with N=4, offer N=6 in the 2nd high cycle → `cfg_ready`=0 until the boundary; the current period completes as 1100, then 111000 repeats; `active_div`=6 from the boundary edge.
- **Illegal divisors:** offer N=0, then N=1, then (without the macro) N=5 → each gives a 1-cycle `cfg_err` one cycle after acceptance, `active_div` stays 4, `clk_out` pattern is unchanged. With `CLKDIV_ODD_EN`, N=5 gives 11100 and no `cfg_err`.
- **Disable mid-high:** drop `en` in the 1st high cycle with N=6 → 111000 completes, then `clk_out`=0 and `busy`=0. Re-asserting `en` produces a rise 1 cycle later together with `tick`.
- **Reset mid-operation:** assert `rst` for 1 cycle during a high phase with N=6 pending → next edge gives `clk_out`=0, `busy`=0, `cfg_ready`=1, `active_div`=4; the pending divisor is never applied.
- **Boundary collision:** accept N=8 in the boundary cycle while `en`=0 → state becomes STOP with `active_div` still the old value for that edge, then `active_div`=8 one cycle later; the next enable produces 11110000.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake between a host (master) and clk_div_ctrl (slave).
interface clk_div_ctrl_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider; enable and divisor changes land on period boundaries.
// Optional feature: define CLKDIV_ODD_EN to allow odd divisors (high phase one cycle longer).
module clk_div_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned RESET_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    clk_div_ctrl_if.slave    cfg,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] active_div
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_div_nxt;
    logic [CNT_W-1:0] active_div_nxt;
    logic             pend_valid;
    logic             pend_valid_nxt;
    logic             clk_out_nxt;
    logic             tick_nxt;
    logic             cfg_ready_nxt;
    logic             cfg_err_nxt;
    logic             xfer;
    logic             div_legal;
    logic             phase_end;
    logic             boundary;

    // Counter reload values: high = ceil(N/2) cycles, low = floor(N/2) cycles.
    function automatic logic [CNT_W-1:0] high_m1(input logic [CNT_W-1:0] n);
        return (n >> 1) + CNT_W'(n[0]) - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] low_m1(input logic [CNT_W-1:0] n);
        return (n >> 1) - CNT_W'(1);
    endfunction

`ifdef CLKDIV_ODD_EN
    assign div_legal = (cfg.cfg_div >= CNT_W'(2));
`else
    assign div_legal = (cfg.cfg_div >= CNT_W'(2)) && !cfg.cfg_div[0];
`endif

    assign xfer      = cfg.cfg_valid && cfg.cfg_ready;
    assign phase_end = (cnt == '0);
    assign boundary  = (state == ST_RUN) && phase_end && !clk_out;

    // State and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state         <= ST_STOP;
            cnt           <= '0;
            clk_out       <= 1'b0;
            tick          <= 1'b0;
            busy          <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= 1'b0;
            active_div    <= CNT_W'(RESET_DIV);
            pend_div      <= '0;
            pend_valid    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            clk_out       <= clk_out_nxt;
            tick          <= tick_nxt;
            busy          <= (state_nxt == ST_RUN);
            cfg.cfg_ready <= cfg_ready_nxt;
            cfg.cfg_err   <= cfg_err_nxt;
            active_div    <= active_div_nxt;
            pend_div      <= pend_div_nxt;
            pend_valid    <= pend_valid_nxt;
        end
    end

    // Leave RUN only at a period boundary with en low.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: if (en) state_nxt = ST_RUN;
            ST_RUN:  if (boundary && !en) state_nxt = ST_STOP;
            default: state_nxt = ST_STOP;
        endcase
    end

    always_comb begin
        cnt_nxt        = cnt;
        clk_out_nxt    = clk_out;
        tick_nxt       = 1'b0;
        cfg_ready_nxt  = cfg.cfg_ready;
        cfg_err_nxt    = 1'b0;
        active_div_nxt = active_div;
        pend_div_nxt   = pend_div;
        pend_valid_nxt = pend_valid;

        // A pending divisor retires at a RUN boundary or in the first STOP cycle.
        if (pend_valid && ((state == ST_STOP) || boundary)) begin
            active_div_nxt = pend_div;
            pend_valid_nxt = 1'b0;
            cfg_ready_nxt  = 1'b1;
        end

        // cfg_ready is low while pending, so this never collides with the retire above.
        if (xfer) begin
            if (!div_legal) begin
                cfg_err_nxt = 1'b1;
            end else if (state == ST_STOP) begin
                active_div_nxt = cfg.cfg_div;
            end else begin
                pend_div_nxt   = cfg.cfg_div;
                pend_valid_nxt = 1'b1;
                cfg_ready_nxt  = 1'b0;
            end
        end

        if (state == ST_STOP) begin
            clk_out_nxt = 1'b0;
            if (en) begin
                clk_out_nxt = 1'b1;
                tick_nxt    = 1'b1;
                cnt_nxt     = high_m1(active_div_nxt);
            end
        end else if (!phase_end) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else if (clk_out) begin
            clk_out_nxt = 1'b0;
            cnt_nxt     = low_m1(active_div);
        end else if (en) begin
            clk_out_nxt = 1'b1;
            tick_nxt    = 1'b1;
            cnt_nxt     = high_m1(active_div_nxt);
        end else begin
            clk_out_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios with literal expectations plus randomized
// traffic compared each cycle against a period-position model.
module tb_clk_div_ctrl;
    localparam int unsigned CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] active_div;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_div_ctrl #(.CNT_W(CNT_W), .RESET_DIV(4)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg_if.slave),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .active_div (active_div)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    function automatic void check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic bit legal(input int d);
`ifdef CLKDIV_ODD_EN
        return d >= 2;
`else
        return (d >= 2) && (d % 2 == 0);
`endif
    endfunction

    // Model: position inside the current period, active and pending divisors.
    int m_n    = 4;
    int m_pos  = 0;
    int m_pend = -1;
    bit m_run  = 1'b0;
    bit m_err  = 1'b0;

    always @(posedge clk_in) begin : model
        int d;
        bit xfer;
        d    = int'(cfg_if.cfg_div);
        xfer = cfg_if.cfg_valid && (m_pend < 0);
        if (rst) begin
            m_n = 4; m_pos = 0; m_pend = -1; m_run = 1'b0; m_err = 1'b0;
        end else begin
            m_err = xfer && !legal(d);
            if (!m_run) begin
                if (m_pend >= 0) begin
                    m_n = m_pend; m_pend = -1;
                end else if (xfer && legal(d)) begin
                    m_n = d;
                end
                if (en) begin
                    m_run = 1'b1; m_pos = 0;
                end
            end else begin
                if (m_pos == m_n - 1) begin
                    if (m_pend >= 0) begin
                        m_n = m_pend; m_pend = -1;
                    end
                    if (en) m_pos = 0;
                    else    m_run = 1'b0;
                end else begin
                    m_pos++;
                end
                if (xfer && legal(d)) m_pend = d;
            end
        end
    end

    always @(negedge clk_in) begin : compare
        if (chk_on) begin
            check("model.clk_out",    int'(clk_out),    int'(m_run && (m_pos < (m_n + 1) / 2)));
            check("model.tick",       int'(tick),       int'(m_run && (m_pos == 0)));
            check("model.busy",       int'(busy),       int'(m_run));
            check("model.active_div", int'(active_div), m_n);
            check("model.cfg_ready",  int'(cfg_if.cfg_ready), int'(m_pend < 0));
            check("model.cfg_err",    int'(cfg_if.cfg_err),   int'(m_err));
        end
    end

    task automatic cyc();
        @(negedge clk_in);
    endtask

    // Literal N-cycle pattern: ceil(N/2) ones then floor(N/2) zeros, tick on the first one.
    task automatic check_period(input string name, input int n, input int count);
        for (int k = 0; k < count; k++) begin
            check({name, ".clk_out"}, int'(clk_out), int'((k % n) < (n + 1) / 2));
            check({name, ".tick"},    int'(tick),    int'((k % n) == 0));
            check({name, ".busy"},    int'(busy),    1);
            cyc();
        end
    endtask

    task automatic wait_tick(input string name);
        int k = 0;
        while (!tick && k < 64) begin
            cyc();
            k++;
        end
        check({name, ".tick_seen"}, int'(tick), 1);
    endtask

    function automatic logic [CNT_W-1:0] pick_div();
        case ($urandom_range(0, 11))
            0:       return CNT_W'(0);
            1:       return CNT_W'(1);
            2:       return CNT_W'(2);
            3:       return CNT_W'(3);
            4:       return CNT_W'(4);
            5:       return CNT_W'(5);
            6:       return CNT_W'(6);
            7:       return CNT_W'(7);
            8:       return CNT_W'(8);
            9:       return CNT_W'(12);
            default: return CNT_W'($urandom_range(2, 30));
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        repeat (2) cyc();
        chk_on = 1'b1;

        check("reset.clk_out",    int'(clk_out),    0);
        check("reset.tick",       int'(tick),       0);
        check("reset.busy",       int'(busy),       0);
        check("reset.active_div", int'(active_div), 4);
        check("reset.cfg_ready",  int'(cfg_if.cfg_ready), 1);
        check("reset.cfg_err",    int'(cfg_if.cfg_err),   0);

        // Default run: first rise one edge after en is sampled.
        rst = 1'b0;
        en  = 1'b1;
        cyc();
        check_period("default", 4, 8);

        // Reconfigure to 6 during the 2nd high cycle.
        cyc();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = CNT_W'(6);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        check("reconf.clk_low",   int'(clk_out), 0);
        check("reconf.ready_low", int'(cfg_if.cfg_ready), 0);
        check("reconf.div_old",   int'(active_div), 4);
        cyc();
        check("reconf.ready_low2", int'(cfg_if.cfg_ready), 0);
        cyc();
        check("reconf.div_new",   int'(active_div), 6);
        check("reconf.ready_hi",  int'(cfg_if.cfg_ready), 1);
        check_period("n6", 6, 12);

        // Illegal divisors, spaced so each error pulse width is visible.
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = CNT_W'(0);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        check("ill0.err", int'(cfg_if.cfg_err), 1);
        cyc();
        check("ill0.err_width", int'(cfg_if.cfg_err), 0);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = CNT_W'(1);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        check("ill1.err", int'(cfg_if.cfg_err), 1);
        cyc();
        check("ill1.err_width", int'(cfg_if.cfg_err), 0);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = CNT_W'(5);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        check("ill.div_kept", int'(active_div), 6);
        check("ill.clk_low",  int'(clk_out), 0);
`ifdef CLKDIV_ODD_EN
        check("odd5.err", int'(cfg_if.cfg_err), 0);
        cyc();
        check_period("odd5", 5, 10);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = CNT_W'(6);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        wait_tick("back6");
        check("back6.div", int'(active_div), 6);
`else
        check("ill5.err", int'(cfg_if.cfg_err), 1);
        cyc();
        check_period("n6_after_err", 6, 6);
`endif

        // Disable in the 1st high cycle: the period completes, then STOP.
        en = 1'b0;
        check_period("dis", 6, 6);
        check("dis.clk_out", int'(clk_out), 0);
        check("dis.busy",    int'(busy),    0);
        cyc();
        check("dis.clk_out2", int'(clk_out), 0);
        en = 1'b1;
        cyc();
        check("reen.clk_out", int'(clk_out), 1);
        check("reen.tick",    int'(tick),    1);

        // Reset mid-high with a divisor pending.
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = CNT_W'(8);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        check("rstmid.pending", int'(cfg_if.cfg_ready), 0);
        check("rstmid.high",    int'(clk_out), 1);
        rst = 1'b1;
        en  = 1'b0;
        cyc();
        rst = 1'b0;
        check("rstmid.clk_out",    int'(clk_out), 0);
        check("rstmid.busy",       int'(busy), 0);
        check("rstmid.cfg_ready",  int'(cfg_if.cfg_ready), 1);
        check("rstmid.active_div", int'(active_div), 4);
        en = 1'b1;
        cyc();
        check_period("post_rst", 4, 8);

        // Boundary collision: accept 8 in the boundary cycle while en drops.
        cyc();
        cyc();
        en = 1'b0;
        cyc();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = CNT_W'(8);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        check("coll.busy",    int'(busy), 0);
        check("coll.div_old", int'(active_div), 4);
        cyc();
        check("coll.div_new", int'(active_div), 8);
        check("coll.ready",   int'(cfg_if.cfg_ready), 1);
        en = 1'b1;
        cyc();
        check_period("n8", 8, 16);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 39) == 0) en = !en;
            cfg_if.cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_if.cfg_div   = pick_div();
            cyc();
        end
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        en = 1'b1;
        wait_tick("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
